// File: rtl/dmem_write_buffer_pkg.sv
// Shared sizing for the posted-store buffer between the core data port and dmem.
package dmem_write_buffer_pkg;

  localparam int WB_WIDTH     = 32;
  localparam int WB_ADDRBITS  = 16;
  localparam int WB_DEPTH     = 4;
  localparam int WB_PTRBITS   = 2;
  localparam int WB_ENTRYBITS = WB_ADDRBITS + WB_WIDTH;

endpackage

// File: rtl/dmem_write_buffer_wb_fifo.sv
// Circular store queue: holds {addr, data} entries in program order, exposes the
// head entry for draining plus every entry and its valid bit for load snooping.
module wb_fifo
  import dmem_write_buffer_pkg::*;
#(
  parameter int WIDTH    = WB_WIDTH,
  parameter int ADDRBITS = WB_ADDRBITS,
  parameter int DEPTH    = WB_DEPTH,
  parameter int PTRBITS  = WB_PTRBITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic                                  pop,
  input  logic [ADDRBITS-1:0]                   push_addr,
  input  logic [WIDTH-1:0]                      push_data,
  output logic [ADDRBITS-1:0]                   head_addr,
  output logic [WIDTH-1:0]                      head_data,
  output logic [DEPTH*(ADDRBITS+WIDTH)-1:0]     entries,
  output logic [DEPTH-1:0]                      valid,
  output logic [PTRBITS-1:0]                    head_ptr,
  output logic                                  full,
  output logic                                  empty
);

  localparam int EB = ADDRBITS + WIDTH;

  logic [EB-1:0]      store_q [DEPTH];
  logic [PTRBITS-1:0] head;
  logic [PTRBITS-1:0] tail;
  logic [PTRBITS:0]   count;
  logic               do_push;
  logic               do_pop;
  logic [PTRBITS-1:0] age;

  assign full     = (count == (PTRBITS+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_ptr = head;

  assign head_addr = store_q[head][EB-1:WIDTH];
  assign head_data = store_q[head][WIDTH-1:0];

  // Entry storage: written at tail on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else if (do_push) begin
      store_q[tail] <= {push_addr, push_data};
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTRBITS'(1);
      if (do_pop)  head <= head + PTRBITS'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTRBITS+1)'(1);
        2'b01:   count <= count - (PTRBITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Flatten storage and mark an entry valid when its distance from head is below count.
  always_comb begin
    entries = '0;
    valid   = '0;
    age     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i*EB +: EB] = store_q[i];
      age                 = PTRBITS'(i) - head;
      valid[i]            = ({1'b0, age} < count);
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer: stores retire into wb_fifo in one cycle, drain to dmem on
// every non-load cycle, and loads see the youngest matching queued store.
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int WIDTH    = WB_WIDTH,
  parameter int ADDRBITS = WB_ADDRBITS,
  parameter int DEPTH    = WB_DEPTH,
  parameter int PTRBITS  = WB_PTRBITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_we,
  input  logic                cpu_re,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]    cpu_wdata,
  output logic [WIDTH-1:0]    cpu_rdata,
  output logic                cpu_stall,
  output logic                mem_we,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                empty
);

  localparam int EB = ADDRBITS + WIDTH;

  logic [ADDRBITS-1:0]      head_addr;
  logic [WIDTH-1:0]         head_data;
  logic [DEPTH*EB-1:0]      entries;
  logic [DEPTH-1:0]         valid;
  logic [PTRBITS-1:0]       head_ptr;
  logic                     full;
  logic                     load;
  logic                     drain;
  logic                     push;
  logic                     hit;
  logic [WIDTH-1:0]         fwd_data;
  logic [PTRBITS-1:0]       idx;
  logic [EB-1:0]            ent;

  // A store with a load asserted is still a store; cpu_re is ignored then.
  assign load      = cpu_re & ~cpu_we;
  assign cpu_stall = cpu_we & full;
  assign push      = cpu_we & ~full;
  // A full-queue store still drains, so the stall clears after one cycle.
  assign drain     = ~empty & ~load;

  assign mem_we    = drain;
  assign mem_addr  = drain ? head_addr : cpu_addr;
  assign mem_wdata = drain ? head_data : '0;

  wb_fifo #(
    .WIDTH    (WIDTH),
    .ADDRBITS (ADDRBITS),
    .DEPTH    (DEPTH),
    .PTRBITS  (PTRBITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (drain),
    .push_addr (cpu_addr),
    .push_data (cpu_wdata),
    .head_addr (head_addr),
    .head_data (head_data),
    .entries   (entries),
    .valid     (valid),
    .head_ptr  (head_ptr),
    .full      (full),
    .empty     (empty)
  );

  // Walk oldest to youngest from head; a later hit overrides, leaving the youngest match.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    ent      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTRBITS'(k);
      ent = entries[int'(idx)*EB +: EB];
      if (valid[idx] && (ent[EB-1:WIDTH+2] == cpu_addr[ADDRBITS-1:2])) begin
        hit      = 1'b1;
        fwd_data = ent[WIDTH-1:0];
      end
    end
  end

  assign cpu_rdata = (load & hit) ? fwd_data : mem_rdata;

endmodule
